demux_stream: RTL and testbench

Parametrised successor of the 8-way combinational demux. It routes a valid/ready data stream to one of `NUM_CH` output channels, selected per beat by `i_sel`. Each channel has a registered output stage with independent backpressure. It sits between the link-layer receive path and per-channel consumers (e.g. TLP/DLLP handlers, status FIFOs).

---
 rtl/demux_stream_pkg.sv | 10 +
 rtl/demux_stream_reg_slice.sv | 35 +++
 rtl/demux_stream.sv | 123 ++++++++++++
 tb/tb_demux_stream.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_stream_pkg.sv
// demux_stream shared definitions: packet-lock FSM state encoding.
// Only used by the build with DEMUX_STREAM_PKT_LOCK_EN defined.
package demux_stream_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/demux_stream_reg_slice.sv
// stream_reg_slice: one-entry output register with valid/ready hold.
// Load wins over drain, so a beat arriving while the old one leaves keeps
// the slice valid with the new payload.
module stream_reg_slice #(
  parameter int WIDTH = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Hold register: capture on load, clear valid once the consumer takes it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/demux_stream.sv
// demux_stream: routes one valid/ready stream to NUM_CH registered outputs.
// Optional packet lock is enabled with the macro DEMUX_STREAM_PKT_LOCK_EN;
// when it is undefined every beat routes on its own i_sel.
module demux_stream
  import demux_stream_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_CH     = 8,
  localparam int SEL_WIDTH  = $clog2(NUM_CH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic [SEL_WIDTH-1:0]         i_sel,
  input  logic                         i_last,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_data,
  output logic [NUM_CH-1:0]            o_last,
  output logic [NUM_CH-1:0]            o_valid,
  input  logic [NUM_CH-1:0]            i_ready,
  output logic                         o_drop
);

  logic [SEL_WIDTH-1:0] w_sel_eff;
  logic                 w_in_range;
  logic                 w_sel_ready;
  logic                 w_accept;
  logic [NUM_CH-1:0]    w_load;
  logic [NUM_CH-1:0]    w_valid;
  logic                 r_drop;

`ifdef DEMUX_STREAM_PKT_LOCK_EN
  lock_state_t          r_state;
  lock_state_t          w_state_nxt;
  logic [SEL_WIDTH-1:0] r_lock_sel;

  // Lock state register; the destination is latched on a packet's first beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_lock_sel <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && (r_state == ST_IDLE) && !i_last) begin
        r_lock_sel <= i_sel;
      end
    end
  end

  // Next state: lock after a non-final first beat, unlock after the final beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept && !i_last) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_accept &&  i_last) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: while locked the stored select overrides i_sel.
  always_comb begin
    w_sel_eff = (r_state == ST_LOCKED) ? r_lock_sel : i_sel;
  end
`else
  assign w_sel_eff = i_sel;
`endif

  assign w_in_range = (int'(w_sel_eff) < NUM_CH);

  // Ready mux: an out-of-range select matches no channel and stays ready.
  always_comb begin
    w_sel_ready = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_sel_eff == SEL_WIDTH'(k)) begin
        w_sel_ready = !w_valid[k] || i_ready[k];
      end
    end
  end

  assign o_ready  = w_sel_ready;
  assign w_accept = i_valid && w_sel_ready;

  // Select decode: one-hot load strobe for the addressed channel.
  always_comb begin
    w_load = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_load[k] = w_accept && (w_sel_eff == SEL_WIDTH'(k));
    end
  end

  // Drop pulse for an accepted beat whose destination does not exist.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_accept && !w_in_range;
    end
  end

  assign o_drop  = r_drop;
  assign o_valid = w_valid;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DATA_WIDTH:0] w_q;

    stream_reg_slice #(
      .WIDTH (DATA_WIDTH + 1)
    ) u_slice (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_load[g]),
      .i_data  ({i_last, i_data}),
      .i_ready (i_ready[g]),
      .o_data  (w_q),
      .o_valid (w_valid[g])
    );

    assign o_data[g*DATA_WIDTH +: DATA_WIDTH] = w_q[DATA_WIDTH-1:0];
    assign o_last[g]                          = w_q[DATA_WIDTH];
  end

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: 8-channel instance driven from a vector table,
// plus a 6-channel instance for the out-of-range drop path.
module tb_demux_stream;

`ifdef DEMUX_STREAM_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-channel DUT
  logic [7:0]  data8  = '0;
  logic [2:0]  sel8   = '0;
  logic        last8  = 1'b0;
  logic        valid8 = 1'b0;
  logic [7:0]  ready8 = 8'hFF;
  logic        o_ready8;
  logic [63:0] o_data8;
  logic [7:0]  o_last8;
  logic [7:0]  o_valid8;
  logic        o_drop8;

  // 6-channel DUT
  logic [7:0]  data6  = '0;
  logic [2:0]  sel6   = '0;
  logic        last6  = 1'b1;
  logic        valid6 = 1'b0;
  logic [5:0]  ready6 = 6'h3F;
  logic        o_ready6;
  logic [47:0] o_data6;
  logic [5:0]  o_last6;
  logic [5:0]  o_valid6;
  logic        o_drop6;

  demux_stream #(.DATA_WIDTH(8), .NUM_CH(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_data(data8), .i_sel(sel8), .i_last(last8),
    .i_valid(valid8), .o_ready(o_ready8), .o_data(o_data8), .o_last(o_last8),
    .o_valid(o_valid8), .i_ready(ready8), .o_drop(o_drop8)
  );

  demux_stream #(.DATA_WIDTH(8), .NUM_CH(6)) u_dut6 (
    .i_clk(clk), .i_rst(rst), .i_data(data6), .i_sel(sel6), .i_last(last6),
    .i_valid(valid6), .o_ready(o_ready6), .o_data(o_data6), .o_last(o_last6),
    .o_valid(o_valid6), .i_ready(ready6), .o_drop(o_drop6)
  );

  typedef struct {
    logic [7:0] d;
    logic [2:0] sel;
    logic       last;
    logic       vld;
    logic [7:0] rdy;
    logic       e_rdy;
    logic [7:0] e_vld;
    logic       chk;
    int         ch;
    logic [7:0] e_d;
    logic       e_last;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [7:0] d, input logic [2:0] sel,
                              input logic last, input logic vld,
                              input logic [7:0] rdy, input logic e_rdy,
                              input logic [7:0] e_vld, input logic chk,
                              input int ch, input logic [7:0] e_d,
                              input logic e_last);
    vec_t v;
    v.d = d; v.sel = sel; v.last = last; v.vld = vld; v.rdy = rdy;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.chk = chk; v.ch = ch;
    v.e_d = e_d; v.e_last = e_last;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the 8-channel DUT, return at the negedge.
  task automatic step(input logic [7:0] d, input logic [2:0] sel,
                      input logic last, input logic vld, input logic [7:0] rdy);
    @(posedge clk);
    #1;
    data8 = d; sel8 = sel; last8 = last; valid8 = vld; ready8 = rdy;
    @(negedge clk);
  endtask

  initial begin
    logic lst;
    logic prev_last;

    // --- reset check ---
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid8", o_valid8, 8'h00);
    chk("rst_data8",  o_data8,  64'h0);
    chk("rst_last8",  o_last8,  8'h00);
    chk("rst_drop8",  o_drop8,  1'b0);
    chk("rst_ready8", o_ready8, 1'b1);
    chk("rst_valid6", o_valid6, 6'h00);
    @(posedge clk);
    #1 rst = 1'b0;

    // --- vector table ---
    tbl.push_back(mk(8'h00, 3'd0, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 0, 8'h00, 1'b0));
    // single beat to channel 3
    tbl.push_back(mk(8'hA5, 3'd3, 1'b1, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 0, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 3'd0, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h08, 1'b1, 3, 8'hA5, 1'b1));
    tbl.push_back(mk(8'h00, 3'd0, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 0, 8'h00, 1'b0));
    // backpressure on channel 2, channel 5 flows
    tbl.push_back(mk(8'h11, 3'd2, 1'b1, 1'b1, 8'hFB, 1'b1, 8'h00, 1'b0, 0, 8'h00, 1'b0));
    tbl.push_back(mk(8'h22, 3'd2, 1'b1, 1'b1, 8'hFB, 1'b0, 8'h04, 1'b1, 2, 8'h11, 1'b1));
    tbl.push_back(mk(8'h33, 3'd5, 1'b1, 1'b1, 8'hFB, 1'b1, 8'h04, 1'b1, 2, 8'h11, 1'b1));
    tbl.push_back(mk(8'h00, 3'd0, 1'b1, 1'b0, 8'hFB, 1'b1, 8'h24, 1'b1, 5, 8'h33, 1'b1));
    tbl.push_back(mk(8'h00, 3'd0, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h04, 1'b1, 2, 8'h11, 1'b1));
    tbl.push_back(mk(8'h00, 3'd0, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 0, 8'h00, 1'b0));
    // back-to-back streaming 0x00..0x0F, channels cycling 0..7
    prev_last = 1'b0;
    for (int i = 0; i < 16; i++) begin
      lst = LOCK ? 1'b1 : i[0];
      if (i == 0)
        tbl.push_back(mk(8'(i), 3'(i % 8), lst, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 0, 8'h00, 1'b0));
      else
        tbl.push_back(mk(8'(i), 3'(i % 8), lst, 1'b1, 8'hFF, 1'b1,
                         8'(1 << ((i - 1) % 8)), 1'b1, (i - 1) % 8, 8'(i - 1), prev_last));
      prev_last = lst;
    end
    tbl.push_back(mk(8'h00, 3'd0, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h80, 1'b1, 7, 8'h0F, prev_last));
    // reload of a draining channel in the same cycle
    tbl.push_back(mk(8'h40, 3'd1, 1'b1, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 0, 8'h00, 1'b0));
    tbl.push_back(mk(8'h41, 3'd1, 1'b1, 1'b1, 8'hFF, 1'b1, 8'h02, 1'b1, 1, 8'h40, 1'b1));
    tbl.push_back(mk(8'h00, 3'd0, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h02, 1'b1, 1, 8'h41, 1'b1));
    tbl.push_back(mk(8'h00, 3'd0, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 0, 8'h00, 1'b0));

    foreach (tbl[i]) begin
      step(tbl[i].d, tbl[i].sel, tbl[i].last, tbl[i].vld, tbl[i].rdy);
      chk($sformatf("v%0d_ready", i), o_ready8, tbl[i].e_rdy);
      chk($sformatf("v%0d_valid", i), o_valid8, tbl[i].e_vld);
      if (tbl[i].chk) begin
        chk($sformatf("v%0d_data_ch%0d", i, tbl[i].ch), o_data8[tbl[i].ch*8 +: 8], tbl[i].e_d);
        chk($sformatf("v%0d_last_ch%0d", i, tbl[i].ch), o_last8[tbl[i].ch], tbl[i].e_last);
      end
    end
    chk("drop8_never", o_drop8, 1'b0);
    step(8'h00, 3'd0, 1'b1, 1'b0, 8'hFF);

    // --- 6 channels: out-of-range select is dropped ---
    @(posedge clk);
    #1 data6 = 8'hEE; sel6 = 3'd7; last6 = 1'b1; valid6 = 1'b1;
    @(negedge clk);
    chk("oor_ready", o_ready6, 1'b1);
    chk("oor_drop_pre", o_drop6, 1'b0);
    @(posedge clk);
    #1 valid6 = 1'b0;
    @(negedge clk);
    chk("oor_drop", o_drop6, 1'b1);
    chk("oor_valid", o_valid6, 6'h00);
    @(posedge clk);
    #1 data6 = 8'h5A; sel6 = 3'd5; valid6 = 1'b1;
    @(negedge clk);
    chk("oor_drop_end", o_drop6, 1'b0);
    @(posedge clk);
    #1 valid6 = 1'b0;
    @(negedge clk);
    chk("top_ch_valid", o_valid6, 6'h20);
    chk("top_ch_data", o_data6[47:40], 8'h5A);
    chk("top_ch_drop", o_drop6, 1'b0);

`ifdef DEMUX_STREAM_PKT_LOCK_EN
    // --- packet lock: 4-beat packet stays on channel 1 ---
    step(8'h50, 3'd1, 1'b0, 1'b1, 8'hFF);
    chk("pkt_b0_valid", o_valid8, 8'h00);
    step(8'h51, 3'd4, 1'b0, 1'b1, 8'hFF);
    chk("pkt_b1_valid", o_valid8, 8'h02);
    chk("pkt_b0_data", o_data8[15:8], 8'h50);
    step(8'h52, 3'd4, 1'b0, 1'b1, 8'hFF);
    chk("pkt_b2_valid", o_valid8, 8'h02);
    chk("pkt_b1_data", o_data8[15:8], 8'h51);
    step(8'h53, 3'd4, 1'b1, 1'b1, 8'hFF);
    chk("pkt_b3_valid", o_valid8, 8'h02);
    chk("pkt_b2_data", o_data8[15:8], 8'h52);
    chk("pkt_b2_last", o_last8[1], 1'b0);
    step(8'h60, 3'd4, 1'b1, 1'b1, 8'hFF);
    chk("pkt_b3_valid2", o_valid8, 8'h02);
    chk("pkt_b3_data", o_data8[15:8], 8'h53);
    chk("pkt_b3_last", o_last8[1], 1'b1);
    step(8'h00, 3'd0, 1'b1, 1'b0, 8'hFF);
    chk("pkt2_valid", o_valid8, 8'h10);
    chk("pkt2_data", o_data8[39:32], 8'h60);

    // --- packet whose first select is out of range is dropped in full ---
    @(posedge clk);
    #1 data6 = 8'hB0; sel6 = 3'd7; last6 = 1'b0; valid6 = 1'b1;
    @(negedge clk);
    chk("lkdrop_ready", o_ready6, 1'b1);
    @(posedge clk);
    #1 data6 = 8'hB1; sel6 = 3'd2; last6 = 1'b1;
    @(negedge clk);
    chk("lkdrop_b0", o_drop6, 1'b1);
    chk("lkdrop_ready2", o_ready6, 1'b1);
    @(posedge clk);
    #1 data6 = 8'h2C; sel6 = 3'd2; last6 = 1'b1;
    @(negedge clk);
    chk("lkdrop_b1", o_drop6, 1'b1);
    chk("lkdrop_valid", o_valid6, 6'h00);
    @(posedge clk);
    #1 valid6 = 1'b0;
    @(negedge clk);
    chk("lkdrop_end", o_drop6, 1'b0);
    chk("lkdrop_next_valid", o_valid6, 6'h04);
    chk("lkdrop_next_data", o_data6[23:16], 8'h2C);
`endif

    // --- reset in the middle of a packet ---
    step(8'h70, 3'd1, 1'b0, 1'b1, 8'hFF);
    chk("mid_b0_ready", o_ready8, 1'b1);
    step(8'h71, 3'd4, 1'b0, 1'b1, 8'hFF);
    chk("mid_b1_ready", o_ready8, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1; valid8 = 1'b0; ready8 = 8'h00;
    @(negedge clk);
    chk("mid_pending_valid", o_valid8, LOCK ? 8'h02 : 8'h10);
    chk("mid_pending_data", LOCK ? o_data8[15:8] : o_data8[39:32], 8'h71);
    @(posedge clk);
    #1 rst = 1'b0;
    data8 = 8'h72; sel8 = 3'd4; last8 = 1'b1; valid8 = 1'b1; ready8 = 8'hFF;
    @(negedge clk);
    chk("mid_rst_valid", o_valid8, 8'h00);
    chk("mid_rst_data", o_data8, 64'h0);
    chk("mid_rst_ready", o_ready8, 1'b1);
    step(8'h00, 3'd0, 1'b1, 1'b0, 8'hFF);
    chk("mid_after_valid", o_valid8, 8'h10);
    chk("mid_after_data", o_data8[39:32], 8'h72);
    chk("mid_after_last", o_last8[4], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
